mult_add_seq: RTL and testbench
===============================

Name: mult_add_seq

Overview:
- Sequential radix-2 shift-add multiply-accumulate. Computes product = multiplicand * multiplier + addend, one multiplier bit per clock.
- It is the inverse of the pipelined divider: it rebuilds the dividend from merchant * divisor + remainder.
- Used to self-check divider results and for general fixed-width multiplies where area matters more than throughput.
- One operation is in flight at a time. It uses a data_rdy/res_rdy handshake in the same style as the divider.

Parameters:
- N, 21, multiplicand width (matches divider merchant width).
- M, 13, multiplier and addend width (matches divider divisor/remainder width).
- P, N+M, product width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- data_rdy  input  1  operand-valid strobe; accepted only while busy=0.
- multiplicand  input  N  operand A (unsigned).
- multiplier  input  M  operand B (unsigned).
- addend  input  M  operand C (unsigned).
- busy  output  1  high while an operation is in progress.
- res_rdy  output  1  single-cycle result-valid pulse.
- product  output  P  A*B+C (unsigned), held until the next completion.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, busy=0, res_rdy=0, product=0, internal accumulator/counter/operand registers=0.
  - Reset asserted mid-operation aborts it. No res_rdy is produced, and product returns to 0.
- State machine: IDLE, CALC. busy = (state==CALC), driven combinationally from the state register.
- IDLE:
  - On a rising edge with data_rdy=1: capture A (zero-extended to P), B, and acc <= zero-extend(C); cnt <= 0; state -> CALC.
  - data_rdy=0: remain in IDLE.
- CALC, each edge:
  - If B[cnt]=1, acc <= acc + (A << cnt); otherwise acc unchanged.
  - cnt <= cnt+1.
  - Implement as a shifting operand register (A shifted left by 1, B shifted right by 1 each cycle) rather than a variable shifter.
- Completion:
  - On the edge where cnt==M-1, product <= the final sum, res_rdy <= 1 for exactly one cycle, state -> IDLE.
  - No early termination when the remaining B bits are zero; latency is fixed.
- Latency: data_rdy sampled at edge k gives res_rdy high in the cycle after edge k+M (M=13: 13 cycles). Throughput is one result per M cycles.
- Back-to-back: in the res_rdy cycle the state is already IDLE (busy=0). A data_rdy in that cycle is accepted at the next edge with no bubble.
- data_rdy while busy=1: ignored. Operands are not sampled and the in-flight operation is unaffected.
- Operand stability: operands are sampled only at acceptance. Input changes during CALC have no effect.
- Width rule: max result (2^N-1)(2^M-1)+(2^M-1) = 2^P - 2^N < 2^P. No overflow is possible, so there is no carry-out port. The accumulator is exactly P bits.
- product changes only on a completion edge or reset. res_rdy=0 at all other times.
- Divider pairing: when fed merchant/divisor/remainder from the divider with N=21 and M=13, product[N-1:0] must equal the original dividend and product[P-1:N] must be 0.

Test Plan:
1. Reset then idle: rstn low 3 cycles, release, data_rdy=0 for 20 cycles -> busy=0, res_rdy=0, product=0 throughout.
2. Basic: A=5, B=7, C=3, data_rdy one cycle -> busy high 13 cycles; res_rdy one pulse 13 cycles after the accept edge; product=38, held afterwards.
3. Extremes: A=2^21-1, B=2^13-1, C=2^13-1 -> product=2^34-2^21; second op A=0, B=0, C=0x1ABC -> product=0x1ABC with the same 13-cycle latency.
4. Busy/back-to-back: accept op1 (A=100, B=3, C=1). Pulse data_rdy with A=9, B=9, C=9 mid-CALC -> ignored, result 301. Then assert data_rdy in the res_rdy cycle with A=2, B=2, C=0 -> accepted without a gap; result 4 exactly 13 cycles later.
5. Reset mid-op: accept A=1000, B=1000, C=0; assert rstn at cycle 6 -> busy=0, product=0 immediately, no res_rdy. After release, a new op A=3, B=4, C=2 -> 14.
6. Divider round-trip: random dividend/divisor (divisor≠0) through the divider; feed merchant/divisor/remainder here -> product equals the dividend for 1000 random vectors.

Source files
------------

// File: rtl/mult_add_seq.sv
// mult_add_seq: sequential radix-2 shift-add multiply-accumulate.
// Computes product = multiplicand * multiplier + addend, one multiplier bit
// per clock. Fixed latency of M cycles and one operation in flight at a time.
// Also used to rebuild a dividend from the divider's quotient, divisor and
// remainder.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   data_rdy     operand-valid strobe, accepted only while busy=0
//   multiplicand operand A, N bits unsigned
//   multiplier   operand B, M bits unsigned
//   addend       operand C, M bits unsigned
//   busy         high while an operation is in progress (decoded from state)
//   res_rdy      single-cycle result-valid pulse
//   product      A*B+C, P bits, held until the next completion
module mult_add_seq #(
  parameter int unsigned N = 21,
  parameter int unsigned M = 13,
  localparam int unsigned P = N + M
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         data_rdy,
  input  logic [N-1:0] multiplicand,
  input  logic [M-1:0] multiplier,
  input  logic [M-1:0] addend,
  output logic         busy,
  output logic         res_rdy,
  output logic [P-1:0] product
);

  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(M - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [P-1:0]  a_sh, a_nxt;     // multiplicand, shifted left each step
  logic [M-1:0]  b_sh, b_nxt;     // multiplier, shifted right each step
  logic [P-1:0]  acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [P-1:0]  prod_nxt;
  logic          res_nxt;
  logic [P-1:0]  sum;

  // busy is a pure decode of the state register
  assign busy = (state == CALC);

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      res_rdy <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_sh    <= a_nxt;
      b_sh    <= b_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      product <= prod_nxt;
      res_rdy <= res_nxt;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_nxt = state;
    a_nxt     = a_sh;
    b_nxt     = b_sh;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    prod_nxt  = product;
    res_nxt   = 1'b0;
    // Current multiplier LSB selects whether the shifted multiplicand is added
    sum       = acc + (b_sh[0] ? a_sh : '0);

    case (state)
      IDLE: begin
        if (data_rdy) begin
          a_nxt     = P'(multiplicand);
          b_nxt     = multiplier;
          acc_nxt   = P'(addend);
          cnt_nxt   = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        acc_nxt = sum;
        a_nxt   = a_sh << 1;
        b_nxt   = b_sh >> 1;
        cnt_nxt = cnt + CW'(1);
        // No early exit on zero remaining bits: latency stays fixed at M
        if (cnt == LAST_CNT) begin
          prod_nxt  = sum;
          res_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_add_seq.sv
// Testbench for mult_add_seq: directed vectors feed a scoreboard queue of
// expected products and result cycles; a negedge monitor pops and compares on
// every res_rdy and checks that product holds between completions.
module tb_mult_add_seq;

  localparam int unsigned N = 21;
  localparam int unsigned M = 13;
  localparam int unsigned P = N + M;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         data_rdy = 1'b0;
  logic [N-1:0] multiplicand = '0;
  logic [M-1:0] multiplier = '0;
  logic [M-1:0] addend = '0;
  logic         busy;
  logic         res_rdy;
  logic [P-1:0] product;

  always #5 clk = ~clk;

  mult_add_seq #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .data_rdy     (data_rdy),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .res_rdy      (res_rdy),
    .product      (product)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [P-1:0] exp_q[$];
  int unsigned  expc_q[$];
  logic [P-1:0] held = '0;

  task automatic chk(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each result against the scoreboard, check hold otherwise
  always @(negedge clk) begin : monitor
    logic [P-1:0] e;
    int unsigned  c;
    if (!rstn) begin
      held = '0;
    end else if (res_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_res_rdy: got product %0d with no pending op (cycle %0d)",
                 product, cyc);
      end else begin
        e = exp_q.pop_front();
        c = expc_q.pop_front();
        chk("product", product, e);
        chk("latency_cycle", P'(cyc), P'(c));
        held = e;
      end
    end else begin
      chk("product_hold", product, held);
    end
  end

  // Drive one operand set for one cycle; call at a negedge
  task automatic issue(input logic [N-1:0] a, input logic [M-1:0] b, input logic [M-1:0] c,
                       input logic [P-1:0] e, input bit push);
    data_rdy     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    if (push) begin
      exp_q.push_back(e);
      expc_q.push_back(cyc + M + 1);
    end
    @(negedge clk);
    data_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle_timeout: busy=%0d, required 0 within 40 cycles", busy);
    end
  endtask

  task automatic wait_res();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_rdy && k < 40);
    if (!res_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_res_timeout: res_rdy=%0d, required 1 within 40 cycles", res_rdy);
    end
  endtask

  initial begin
    int unsigned dividend, divisor, quo, rem;
    int k;

    // 1. Reset then idle
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", P'(busy), '0);
      chk("idle_res_rdy", P'(res_rdy), '0);
      chk("idle_product", product, '0);
    end

    // 2. Basic: 5*7+3, busy for exactly M cycles, single res_rdy pulse
    issue(N'(5), M'(7), M'(3), P'(38), 1'b1);
    for (int i = 0; i < int'(M); i++) begin
      chk("basic_busy_high", P'(busy), P'(1));
      @(negedge clk);
    end
    chk("basic_busy_low", P'(busy), '0);
    chk("basic_res_pulse", P'(res_rdy), P'(1));
    @(negedge clk);
    chk("basic_res_single", P'(res_rdy), '0);
    repeat (3) @(negedge clk);

    // 3. Extremes: max operands, then all-zero multiplier
    issue(N'(21'h1F_FFFF), M'(13'h1FFF), M'(13'h1FFF), 34'h3_FFE0_0000, 1'b1);
    wait_idle();
    issue(N'(0), M'(0), M'(13'h1ABC), P'(13'h1ABC), 1'b1);
    wait_idle();
    @(negedge clk);

    // 4. Busy strobe ignored, then back-to-back accept in the res_rdy cycle
    issue(N'(100), M'(3), M'(1), P'(301), 1'b1);
    repeat (3) @(negedge clk);
    issue(N'(9), M'(9), M'(9), '0, 1'b0);
    wait_res();
    issue(N'(2), M'(2), M'(0), P'(4), 1'b1);
    wait_res();
    @(negedge clk);

    // 5. Reset mid-operation aborts it
    issue(N'(1000), M'(1000), M'(0), P'(1000000), 1'b1);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_busy", P'(busy), '0);
    chk("rst_product", product, '0);
    chk("rst_res_rdy", P'(res_rdy), '0);
    exp_q.delete();
    expc_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    issue(N'(3), M'(4), M'(2), P'(14), 1'b1);
    wait_res();

    // 6. Divider round-trip: quotient*divisor+remainder rebuilds the dividend
    for (int i = 0; i < 1000; i++) begin
      dividend = $urandom_range(0, (1 << N) - 1);
      divisor  = $urandom_range(1, (1 << M) - 1);
      quo      = dividend / divisor;
      rem      = dividend % divisor;
      wait_idle();
      issue(N'(quo), M'(divisor), M'(rem), P'(dividend), 1'b1);
    end

    // Drain and confirm every issued op produced a result
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("scoreboard_drained", P'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
